// File: rtl/iter_divider.sv
// Multicycle signed 32-bit divider: magnitude conversion, 32-step restoring
// division, sign restore on the quotient. One-cycle RDY pulse on completion.
module iter_divider #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    // state | meaning
    // IDLE  | waiting for ctrl_DIV
    // RUN   | one restoring step per clock, WIDTH steps total
    // DONE  | publish quotient/exception and pulse RDY
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0]    ONE_W    = WIDTH'(1);
    localparam logic [CNT_BITS-1:0] ONE_C    = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] cnt;
    logic [WIDTH-1:0]    quo, rem, dvs;
    logic                sign, dz;

    logic [WIDTH-1:0]    mag_a, mag_b, quo_signed;
    logic [WIDTH:0]      rem_sh, trial;
    logic                trial_ok;

    always_comb begin
        mag_a      = data_operandA[WIDTH-1] ? (~data_operandA + ONE_W) : data_operandA;
        mag_b      = data_operandB[WIDTH-1] ? (~data_operandB + ONE_W) : data_operandB;
        rem_sh     = {rem, quo[WIDTH-1]};
        // rem_sh < 2*dvs, so bit WIDTH of the wrapped difference is the borrow
        trial      = rem_sh - {1'b0, dvs};
        trial_ok   = ~trial[WIDTH];
        quo_signed = sign ? (~quo + ONE_W) : quo;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ctrl_DIV) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (cnt == LAST_CNT) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            quo            <= '0;
            rem            <= '0;
            dvs            <= '0;
            sign           <= 1'b0;
            dz             <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                quo  <= mag_a;
                dvs  <= mag_b;
                rem  <= '0;
                sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                dz   <= (data_operandB == '0);
                cnt  <= '0;
            end else if (state == RUN) begin
                rem <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], trial_ok};
                cnt <= cnt + ONE_C;
            end else if (state == DONE) begin
                data_result    <= dz ? '0 : quo_signed;
                data_exception <= dz;
                data_resultRDY <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: expected quotient, exception and
// completion cycle are queued at each start and checked on every RDY.
module tb_iter_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] last_res = '0;

    iter_divider #(.WIDTH(32), .CNT_BITS(6)) dut (
        .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 32'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
    endfunction

    // RDY monitor: sampled 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (data_resultRDY === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rdy", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", data_result, e.res);
                    chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
                    chk("rdy_cycle", 32'(cyc), 32'(e.cyc));
                    last_res = e.res;
                end
            end
        end
    end

    // Raise ctrl_DIV for the next edge; any still-pending operation is aborted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        if (sb.size() > 0) void'(sb.pop_back());
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        e.res = model(a, b);
        e.exc = (b == 32'd0);
        e.cyc = cyc + 1 + 33;
        sb.push_back(e);
    endtask

    task automatic release_ctrl();
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        release_ctrl();
        wait_done();
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_div(32'd100, 32'd7);
        run_div(-32'sd100, 32'd7);
        run_div(32'd100, -32'sd7);
        run_div(-32'sd100, -32'sd7);
        run_div(32'd0, 32'd5);
        run_div(32'd5, 32'd9);

        run_div(32'd123, 32'd0);
        run_div(32'd6, 32'd3);

        run_div(32'h8000_0000, 32'hFFFF_FFFF);
        run_div(32'h8000_0000, 32'd1);
        run_div(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // restart mid-run: first op must never complete, output holds meanwhile
        run_div(32'd77, 32'd7);
        issue(32'd1000, 32'd10);
        release_ctrl();
        repeat (10) @(negedge clock);
        issue(32'd50, 32'd5);
        release_ctrl();
        repeat (20) @(negedge clock);
        chk("hold_during_run", data_result, last_res);
        wait_done();

        // ctrl_DIV held for three edges: completion counts from the last one
        issue(32'd9, 32'd2);
        issue(32'd90, 32'd3);
        issue(-32'sd91, 32'd4);
        release_ctrl();
        wait_done();

        // asynchronous reset mid-operation
        issue(32'd64, 32'd8);
        release_ctrl();
        repeat (18) @(negedge clock);
        chk("hold_before_reset", data_result, last_res);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_result", data_result, 32'd0);
        chk("async_rst_exc", {31'd0, data_exception}, 32'd0);
        chk("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        sb.delete();
        last_res = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        run_div(32'd64, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
